nes_debugger_step_controller: RTL and testbench

Sequences NES CPU execution for the debugger: gates the CPU clock enable to provide halt, single-instruction step and free-run-to-breakpoint modes. Sits beside the debugger value bank on the same value-ID bus (IDs 3–8; IDs 1–2 belong to the existing value bank), and drives the CPU's cycle-enable. Detects instruction boundaries from the 6502 SYNC signal, counts executed cycles, and aborts runaway steps with a watchdog.

---
 rtl/nes_debugger_step_controller_if.sv | 11 +
 rtl/nes_debugger_step_controller.sv | 136 +++++++++++++
 tb/tb_nes_debugger_step_controller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_debugger_step_controller_if.sv
// Value-ID bus shared with the debugger value bank.
interface nes_debugger_step_controller_if;
  logic        i_ena;
  logic        i_wea;
  logic [15:0] i_id;
  logic [15:0] i_data;
  logic [15:0] o_data;

  modport master (output i_ena, output i_wea, output i_id, output i_data, input o_data);
  modport slave  (input i_ena, input i_wea, input i_id, input i_data, output o_data);
endinterface

// File: rtl/nes_debugger_step_controller.sv
// Debugger execution sequencer: gates the CPU cycle enable to give halt,
// single-instruction step and run-to-breakpoint, and exposes its control
// and status on value IDs 3..8.
module nes_debugger_step_controller #(
  parameter logic [15:0] STEP_TIMEOUT = 16'd64
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  nes_debugger_step_controller_if.slave        bus,
  input  logic                                 i_cpu_sync,
  input  logic [15:0]                          i_cpu_address,
  output logic                                 o_cpu_clk_en
);

  typedef enum logic [1:0] {ST_HALTED, ST_STEP, ST_RUN} state_e;

  localparam logic [15:0] ID_STEP   = 16'd3;
  localparam logic [15:0] ID_RUN    = 16'd4;
  localparam logic [15:0] ID_BADDR  = 16'd5;
  localparam logic [15:0] ID_BEN    = 16'd6;
  localparam logic [15:0] ID_CYCLES = 16'd7;
  localparam logic [15:0] ID_STATUS = 16'd8;

  state_e      state_q, state_d;
  logic [15:0] cycles_q, cycles_d;
  logic [15:0] break_addr_q, break_addr_d;
  logic        break_en_q, break_en_d;
  logic        break_hit_q, break_hit_d;
  logic        timeout_q, timeout_d;

  logic        wr;
  logic        boundary;
  logic        bp_hit;
  logic        step_last;

  // State and register file; reset returns everything to the halted, cleared state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_HALTED;
      cycles_q     <= 16'd0;
      break_addr_q <= 16'd0;
      break_en_q   <= 1'b0;
      break_hit_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycles_q     <= cycles_d;
      break_addr_q <= break_addr_d;
      break_en_q   <= break_en_d;
      break_hit_q  <= break_hit_d;
      timeout_q    <= timeout_d;
    end
  end

  // Stop detection, CPU cycle enable and combinational read mux
  always_comb begin
    wr        = bus.i_ena && bus.i_wea;
    // CYCLES != 0 keeps a start from halting on the fetch it is parked on
    boundary  = i_cpu_sync && (cycles_q != 16'd0);
    bp_hit    = break_en_q && i_cpu_sync && (i_cpu_address == break_addr_q)
                && (cycles_q != 16'd0);
    case (state_q)
      ST_STEP: o_cpu_clk_en = !boundary;
      ST_RUN:  o_cpu_clk_en = !bp_hit;
      default: o_cpu_clk_en = 1'b0;
    endcase
    bus.o_data = 16'd0;
    if (bus.i_ena) begin
      case (bus.i_id)
        ID_STEP:   bus.o_data = {15'd0, state_q == ST_STEP};
        ID_RUN:    bus.o_data = {15'd0, state_q == ST_RUN};
        ID_BADDR:  bus.o_data = break_addr_q;
        ID_BEN:    bus.o_data = {15'd0, break_en_q};
        ID_CYCLES: bus.o_data = cycles_q;
        ID_STATUS: bus.o_data = {12'd0, timeout_q, break_hit_q,
                                 state_q == ST_RUN, state_q != ST_HALTED};
        default:   bus.o_data = 16'd0;
      endcase
    end
  end

  // Next-state: starts, stops, watchdog, cycle counter and breakpoint registers
  always_comb begin
    state_d      = state_q;
    cycles_d     = cycles_q;
    break_addr_d = break_addr_q;
    break_en_d   = break_en_q;
    break_hit_d  = break_hit_q;
    timeout_d    = timeout_q;
    // This enabled cycle is the one that brings CYCLES up to the limit
    step_last    = ({1'b0, cycles_q} + 17'd1) >= {1'b0, STEP_TIMEOUT};

    if (o_cpu_clk_en && (cycles_q != 16'hFFFF))
      cycles_d = cycles_q + 16'd1;
    if (wr && (bus.i_id == ID_BADDR))
      break_addr_d = bus.i_data;
    if (wr && (bus.i_id == ID_BEN))
      break_en_d = bus.i_data[0];

    case (state_q)
      ST_HALTED: begin
        if (wr && (bus.i_id == ID_STEP) && (bus.i_data == 16'd1)) begin
          state_d     = ST_STEP;
          cycles_d    = 16'd0;
          break_hit_d = 1'b0;
          timeout_d   = 1'b0;
        end else if (wr && (bus.i_id == ID_RUN) && (bus.i_data == 16'd1)) begin
          state_d     = ST_RUN;
          cycles_d    = 16'd0;
          break_hit_d = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      ST_STEP: begin
        if (boundary) begin
          state_d = ST_HALTED;
        end else if (o_cpu_clk_en && step_last) begin
          state_d   = ST_HALTED;
          timeout_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (bp_hit) begin
          state_d     = ST_HALTED;
          break_hit_d = 1'b1;
        end
      end
      default: state_d = ST_HALTED;
    endcase

    // Halt/abort overrides everything; flags set above are kept
    if (wr && (bus.i_id == ID_RUN) && (bus.i_data == 16'd0))
      state_d = ST_HALTED;
  end

endmodule

// File: tb/tb_nes_debugger_step_controller.sv
// Directed bench for the debugger step controller with a small CPU model.
module tb_nes_debugger_step_controller;

  logic        clk;
  logic        rst;
  logic        cpu_sync;
  logic [15:0] cpu_addr;
  logic        clk_en;

  int checks;
  int failures;

  nes_debugger_step_controller_if bus_if ();

  nes_debugger_step_controller #(.STEP_TIMEOUT(16'd64)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .bus           (bus_if),
    .i_cpu_sync    (cpu_sync),
    .i_cpu_address (cpu_addr),
    .o_cpu_clk_en  (clk_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU model: advances one cycle per enabled edge.
  // mode 0: opcode fetches on cycles 0,2,5,8,10 (2- then 3-cycle instrs)
  // mode 1: SYNC stuck low; mode 2: 2-cycle instrs, fetch address C000+cycle
  logic [15:0] cpu_cyc;
  int          cpu_mode;
  logic        cpu_rst;

  always @(posedge clk) begin
    if (cpu_rst) cpu_cyc <= 16'd0;
    else if (clk_en) cpu_cyc <= cpu_cyc + 16'd1;
  end

  always_comb begin
    cpu_addr = 16'hC000 + cpu_cyc;
    case (cpu_mode)
      0:       cpu_sync = (cpu_cyc == 16'd0) || (cpu_cyc == 16'd2) || (cpu_cyc == 16'd5)
                          || (cpu_cyc == 16'd8) || (cpu_cyc == 16'd10);
      1:       cpu_sync = 1'b0;
      default: cpu_sync = ~cpu_cyc[0];
    endcase
  end

  typedef struct {
    logic        ena;
    logic        wea;
    logic [15:0] id;
    logic [15:0] data;
    logic [15:0] exp_data;
    logic        exp_en;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus_if.i_ena  = 1'b0;
    bus_if.i_wea  = 1'b0;
    bus_if.i_id   = 16'd0;
    bus_if.i_data = 16'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] id, input logic [15:0] exp, input string name);
    bus_if.i_ena = 1'b1;
    bus_if.i_wea = 1'b0;
    bus_if.i_id  = id;
    #1;
    chk(name, {16'd0, bus_if.o_data}, {16'd0, exp});
    idle();
  endtask

  task automatic wr(input logic [15:0] id, input logic [15:0] data);
    bus_if.i_ena  = 1'b1;
    bus_if.i_wea  = 1'b1;
    bus_if.i_id   = id;
    bus_if.i_data = data;
    tick();
    idle();
  endtask

  // Counts consecutive enabled cycles, starting in the cycle after a start edge
  task automatic count_en(input int max, output int cnt);
    cnt = 0;
    while (clk_en && (cnt < max)) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    checks   = 0;
    failures = 0;
    cpu_mode = 0;
    cpu_rst  = 1'b1;
    rst      = 1'b1;
    idle();

    tbl[0]  = '{1'b1, 1'b0, 16'd3, 16'd0,     16'd0,     1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'd4, 16'd0,     16'd0,     1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'd5, 16'd0,     16'd0,     1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'd6, 16'd0,     16'd0,     1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'd7, 16'd0,     16'd0,     1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'd8, 16'd0,     16'd0,     1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'd1, 16'd0,     16'd0,     1'b0};
    tbl[7]  = '{1'b1, 1'b1, 16'd5, 16'hC004,  16'd0,     1'b0};
    tbl[8]  = '{1'b1, 1'b0, 16'd5, 16'd0,     16'hC004,  1'b0};
    tbl[9]  = '{1'b1, 1'b1, 16'd6, 16'hFFFF,  16'd0,     1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'd6, 16'd0,     16'd1,     1'b0};
    tbl[11] = '{1'b1, 1'b1, 16'd7, 16'h1234,  16'd0,     1'b0};
    tbl[12] = '{1'b1, 1'b0, 16'd7, 16'd0,     16'd0,     1'b0};
    tbl[13] = '{1'b1, 1'b1, 16'd8, 16'hFFFF,  16'd0,     1'b0};
    tbl[14] = '{1'b1, 1'b0, 16'd8, 16'd0,     16'd0,     1'b0};
    tbl[15] = '{1'b0, 1'b1, 16'd5, 16'd0,     16'd0,     1'b0};
    tbl[16] = '{1'b1, 1'b0, 16'd5, 16'd0,     16'hC004,  1'b0};
    tbl[17] = '{1'b1, 1'b1, 16'd3, 16'd2,     16'd0,     1'b0};
    tbl[18] = '{1'b1, 1'b0, 16'd3, 16'd0,     16'd0,     1'b0};
    tbl[19] = '{1'b1, 1'b1, 16'd4, 16'd2,     16'd0,     1'b0};
    tbl[20] = '{1'b1, 1'b0, 16'd4, 16'd0,     16'd0,     1'b0};
    tbl[21] = '{1'b1, 1'b1, 16'd6, 16'd0,     16'd1,     1'b0};
    tbl[22] = '{1'b1, 1'b0, 16'd6, 16'd0,     16'd0,     1'b0};

    tick();
    tick();
    rst     = 1'b0;
    cpu_rst = 1'b0;
    chk("reset_clk_en", clk_en, 1'b0);

    // Register map, reset values and ignored writes
    for (int i = 0; i < 23; i++) begin
      bus_if.i_ena  = tbl[i].ena;
      bus_if.i_wea  = tbl[i].wea;
      bus_if.i_id   = tbl[i].id;
      bus_if.i_data = tbl[i].data;
      #1;
      chk($sformatf("vec%0d_data", i), {16'd0, bus_if.o_data}, {16'd0, tbl[i].exp_data});
      chk($sformatf("vec%0d_en", i), clk_en, tbl[i].exp_en);
      tick();
      idle();
    end

    // Single steps: 2-cycle then 3-cycle instruction
    cpu_mode = 0;
    wr(16'd3, 16'd1);
    rd(16'd3, 16'd1, "step1_busy");
    count_en(100, cnt);
    chk("step1_en_cycles", cnt, 2);
    tick();
    chk("step1_halted_en", clk_en, 1'b0);
    rd(16'd7, 16'd2, "step1_cycles");
    rd(16'd8, 16'd0, "step1_status");
    rd(16'd3, 16'd0, "step1_step_rd");
    wr(16'd3, 16'd1);
    count_en(100, cnt);
    chk("step2_en_cycles", cnt, 3);
    tick();
    rd(16'd7, 16'd3, "step2_cycles");
    chk("step2_cpu_cyc", {16'd0, cpu_cyc}, 32'd5);

    // Watchdog: no SYNC ever
    cpu_mode = 1;
    wr(16'd3, 16'd1);
    count_en(200, cnt);
    chk("tmo_en_cycles", cnt, 64);
    rd(16'd7, 16'd64, "tmo_cycles");
    rd(16'd8, 16'h0008, "tmo_status");
    rd(16'd3, 16'd0, "tmo_step_rd");

    // Breakpoint at C004 (BREAK_ADDR still C004 from the table)
    cpu_mode = 2;
    cpu_rst  = 1'b1;
    tick();
    cpu_rst  = 1'b0;
    wr(16'd6, 16'd1);
    wr(16'd4, 16'd1);
    count_en(100, cnt);
    chk("bp_en_cycles", cnt, 4);
    chk("bp_fetch_addr", {16'd0, cpu_addr}, 32'hC004);
    tick();
    chk("bp_halted_en", clk_en, 1'b0);
    rd(16'd8, 16'h0004, "bp_status");
    rd(16'd4, 16'd0, "bp_run_rd");
    rd(16'd7, 16'd4, "bp_cycles");
    // Restart while parked on the breakpoint fetch must make progress
    wr(16'd4, 16'd1);
    chk("bp_restart_en", clk_en, 1'b1);
    rd(16'd8, 16'h0003, "bp_restart_status");
    wr(16'd4, 16'd0);
    chk("bp_abort_en", clk_en, 1'b0);
    rd(16'd7, 16'd1, "bp_abort_cycles");
    rd(16'd8, 16'd0, "bp_abort_status");

    // Free run, STEP write ignored, halt by RUN=0 after 10 cycles
    wr(16'd6, 16'd0);
    wr(16'd4, 16'd1);
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("run_en_%0d", i), clk_en, 1'b1);
      if (i == 3) begin
        bus_if.i_ena = 1'b1; bus_if.i_wea = 1'b1; bus_if.i_id = 16'd3; bus_if.i_data = 16'd1;
      end else if (i == 4) begin
        rd(16'd3, 16'd0, "run_step_ignored");
      end else if (i == 5) begin
        rd(16'd4, 16'd1, "run_run_rd");
      end else if (i == 10) begin
        bus_if.i_ena = 1'b1; bus_if.i_wea = 1'b1; bus_if.i_id = 16'd4; bus_if.i_data = 16'd0;
      end
      tick();
      idle();
    end
    chk("run_stop_en", clk_en, 1'b0);
    rd(16'd7, 16'd10, "run_cycles");
    rd(16'd8, 16'd0, "run_status");
    rd(16'd4, 16'd0, "run_run_rd_after");

    // Reset mid-step with a concurrent RUN=1 write
    cpu_mode = 1;
    wr(16'd6, 16'd1);
    wr(16'd3, 16'd1);
    repeat (5) tick();
    chk("rst_pre_en", clk_en, 1'b1);
    rst = 1'b1;
    bus_if.i_ena = 1'b1; bus_if.i_wea = 1'b1; bus_if.i_id = 16'd4; bus_if.i_data = 16'd1;
    tick();
    rst = 1'b0;
    idle();
    chk("rst_mid_en", clk_en, 1'b0);
    for (int id = 3; id <= 8; id++)
      rd(16'(id), 16'd0, $sformatf("rst_mid_id%0d", id));
    tick();
    chk("rst_mid_en_later", clk_en, 1'b0);

    // Reset with a concurrent STEP=1 write from HALTED
    rst = 1'b1;
    bus_if.i_ena = 1'b1; bus_if.i_wea = 1'b1; bus_if.i_id = 16'd3; bus_if.i_data = 16'd1;
    tick();
    rst = 1'b0;
    idle();
    chk("rst_wr_en", clk_en, 1'b0);
    rd(16'd3, 16'd0, "rst_wr_step");
    tick();
    chk("rst_wr_en_later", clk_en, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
